// File: rtl/tt_um_jonathancortez_circle_engine.sv
// rtl/tt_um_jonathancortez_circle_engine.sv - multi-circle VGA pixel renderer with shadow config and bounce animation
// Three-stage pixel pipeline; a frame-start sequencer commits shadow fields and steps each animated circle.
module tt_um_jonathancortez_circle_engine #(
  parameter int          NUM_CIRCLES = 4,
  parameter int          COORD_W     = 10,
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 480,
  parameter logic [23:0] BG_COLOR    = 24'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2:0]         cfg_idx,
  input  logic [2:0]         cfg_addr,
  input  logic [23:0]        cfg_data,
  output logic [7:0]         red,
  output logic [7:0]         green,
  output logic [7:0]         blue,
  output logic               out_valid,
  output logic               hit_any
);

  localparam int DW  = COORD_W + 1;
  localparam int PW  = COORD_W + 2;
  localparam int SQW = 2 * COORD_W + 2;
  localparam int D2W = 2 * COORD_W + 3;
  localparam int RSQ = 2 * COORD_W;
  localparam logic signed [PW-1:0] XMAX = PW'(H_RES - 1);
  localparam logic signed [PW-1:0] YMAX = PW'(V_RES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_ANIM} state_e;

  state_e     state_q, state_d;
  logic [2:0] anim_idx_q, anim_idx_d;
  logic       commit, anim_step, wr;

  logic [COORD_W-1:0]      cx_q [NUM_CIRCLES], cy_q [NUM_CIRCLES], r_q [NUM_CIRCLES], th_q [NUM_CIRCLES];
  logic [23:0]             col_q [NUM_CIRCLES];
  logic signed [4:0]       vx_q [NUM_CIRCLES], vy_q [NUM_CIRCLES];
  logic [1:0]              ctl_q [NUM_CIRCLES];
  logic [COORD_W-1:0]      sh_cx_q [NUM_CIRCLES], sh_cy_q [NUM_CIRCLES], sh_r_q [NUM_CIRCLES], sh_th_q [NUM_CIRCLES];
  logic [23:0]             sh_col_q [NUM_CIRCLES];
  logic signed [4:0]       sh_vx_q [NUM_CIRCLES], sh_vy_q [NUM_CIRCLES];
  logic [1:0]              sh_ctl_q [NUM_CIRCLES];
  logic [7:0]              dirty_q [NUM_CIRCLES];

  logic signed [PW-1:0]    rs [NUM_CIRCLES], nx [NUM_CIRCLES], ny [NUM_CIRCLES];
  logic                    bx [NUM_CIRCLES], by [NUM_CIRCLES];

  always_comb begin
    state_d    = state_q;
    anim_idx_d = anim_idx_q;
    cfg_ready  = 1'b0;
    commit     = 1'b0;
    anim_step  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (frame_start) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit     = 1'b1;
        anim_idx_d = '0;
        state_d    = ST_ANIM;
      end
      ST_ANIM: begin
        anim_step = 1'b1;
        if (anim_idx_q == 3'(NUM_CIRCLES - 1)) state_d = ST_IDLE;
        else anim_idx_d = anim_idx_q + 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      anim_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      anim_idx_q <= anim_idx_d;
    end
  end

  assign wr = cfg_valid && cfg_ready;

  // Candidate positions; a step that would leave the visible area reflects velocity instead of moving.
  always_comb begin
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      rs[i] = $signed({2'b0, r_q[i]});
      nx[i] = $signed({2'b0, cx_q[i]}) + $signed({{(PW-5){vx_q[i][4]}}, vx_q[i]});
      ny[i] = $signed({2'b0, cy_q[i]}) + $signed({{(PW-5){vy_q[i][4]}}, vy_q[i]});
      bx[i] = (nx[i] < rs[i]) || (nx[i] > XMAX - rs[i]);
      by[i] = (ny[i] < rs[i]) || (ny[i] > YMAX - rs[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        cx_q[i] <= '0; cy_q[i] <= '0; r_q[i] <= '0; th_q[i] <= '0;
        col_q[i] <= '0; vx_q[i] <= '0; vy_q[i] <= '0; ctl_q[i] <= '0;
        sh_cx_q[i] <= '0; sh_cy_q[i] <= '0; sh_r_q[i] <= '0; sh_th_q[i] <= '0;
        sh_col_q[i] <= '0; sh_vx_q[i] <= '0; sh_vy_q[i] <= '0; sh_ctl_q[i] <= '0;
        dirty_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        if (wr && cfg_idx == 3'(i)) begin
          dirty_q[i][cfg_addr] <= 1'b1;
          case (cfg_addr)
            3'd0: sh_cx_q[i]  <= cfg_data[COORD_W-1:0];
            3'd1: sh_cy_q[i]  <= cfg_data[COORD_W-1:0];
            3'd2: sh_r_q[i]   <= cfg_data[COORD_W-1:0];
            3'd3: sh_th_q[i]  <= cfg_data[COORD_W-1:0];
            3'd4: sh_col_q[i] <= cfg_data;
            3'd5: sh_vx_q[i]  <= cfg_data[4:0];
            3'd6: sh_vy_q[i]  <= cfg_data[4:0];
            3'd7: sh_ctl_q[i] <= cfg_data[1:0];
          endcase
        end
        if (commit) begin
          dirty_q[i] <= '0;
          if (dirty_q[i][0]) cx_q[i]  <= sh_cx_q[i];
          if (dirty_q[i][1]) cy_q[i]  <= sh_cy_q[i];
          if (dirty_q[i][2]) r_q[i]   <= sh_r_q[i];
          if (dirty_q[i][3]) th_q[i]  <= sh_th_q[i];
          if (dirty_q[i][4]) col_q[i] <= sh_col_q[i];
          if (dirty_q[i][5]) vx_q[i]  <= sh_vx_q[i];
          if (dirty_q[i][6]) vy_q[i]  <= sh_vy_q[i];
          if (dirty_q[i][7]) ctl_q[i] <= sh_ctl_q[i];
        end
        if (anim_step && anim_idx_q == 3'(i) && ctl_q[i] == 2'b11) begin
          if (bx[i]) vx_q[i] <= -vx_q[i];
          else       cx_q[i] <= nx[i][COORD_W-1:0];
          if (by[i]) vy_q[i] <= -vy_q[i];
          else       cy_q[i] <= ny[i][COORD_W-1:0];
        end
      end
    end
  end

  logic signed [DW-1:0]  dx_q [NUM_CIRCLES], dy_q [NUM_CIRCLES];
  logic [COORD_W-1:0]    r1_q [NUM_CIRCLES], th1_q [NUM_CIRCLES];
  logic [23:0]           col1_q [NUM_CIRCLES], col2_q [NUM_CIRCLES];
  logic                  en1_q [NUM_CIRCLES], en2_q [NUM_CIRCLES], riz_q [NUM_CIRCLES];
  logic                  v1_q, v2_q;
  logic signed [SQW-1:0] sqx [NUM_CIRCLES], sqy [NUM_CIRCLES];
  logic [COORD_W-1:0]    ri [NUM_CIRCLES];
  logic [D2W-1:0]        d2_q [NUM_CIRCLES];
  logic [RSQ-1:0]        r2_q [NUM_CIRCLES], ri2_q [NUM_CIRCLES];
  logic [NUM_CIRCLES-1:0] hit;
  logic [23:0]           sel_col;
  logic                  sel_any;

  always_comb begin
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      sqx[i] = SQW'(dx_q[i]) * SQW'(dx_q[i]);
      sqy[i] = SQW'(dy_q[i]) * SQW'(dy_q[i]);
      ri[i]  = (th1_q[i] == '0 || th1_q[i] >= r1_q[i]) ? '0 : r1_q[i] - th1_q[i];
    end
  end

  // Reverse scan so the lowest-index hit wins.
  always_comb begin
    sel_col = BG_COLOR;
    sel_any = 1'b0;
    hit     = '0;
    for (int i = NUM_CIRCLES - 1; i >= 0; i--) begin
      hit[i] = en2_q[i] && (d2_q[i] <= D2W'(r2_q[i])) && (riz_q[i] || d2_q[i] > D2W'(ri2_q[i]));
      if (hit[i]) begin
        sel_col = col2_q[i];
        sel_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; v2_q <= 1'b0;
      out_valid <= 1'b0; hit_any <= 1'b0;
      red <= '0; green <= '0; blue <= '0;
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        dx_q[i] <= '0; dy_q[i] <= '0; r1_q[i] <= '0; th1_q[i] <= '0;
        col1_q[i] <= '0; en1_q[i] <= 1'b0;
        d2_q[i] <= '0; r2_q[i] <= '0; ri2_q[i] <= '0; riz_q[i] <= 1'b0;
        col2_q[i] <= '0; en2_q[i] <= 1'b0;
      end
    end else begin
      v1_q <= pix_valid;
      v2_q <= v1_q;
      for (int i = 0; i < NUM_CIRCLES; i++) begin
        dx_q[i]   <= $signed({1'b0, hcount}) - $signed({1'b0, cx_q[i]});
        dy_q[i]   <= $signed({1'b0, vcount}) - $signed({1'b0, cy_q[i]});
        r1_q[i]   <= r_q[i];
        th1_q[i]  <= th_q[i];
        col1_q[i] <= col_q[i];
        en1_q[i]  <= ctl_q[i][0];
        d2_q[i]   <= {1'b0, sqx[i]} + {1'b0, sqy[i]};
        r2_q[i]   <= RSQ'(r1_q[i]) * RSQ'(r1_q[i]);
        ri2_q[i]  <= RSQ'(ri[i]) * RSQ'(ri[i]);
        riz_q[i]  <= (ri[i] == '0);
        col2_q[i] <= col1_q[i];
        en2_q[i]  <= en1_q[i];
      end
      out_valid <= v2_q;
      hit_any   <= v2_q && sel_any;
      if (v2_q) {red, green, blue} <= sel_col;
      else      {red, green, blue} <= '0;
    end
  end

endmodule

// File: tb/tb_tt_um_jonathancortez_circle_engine.sv
// tb/tb_tt_um_jonathancortez_circle_engine.sv - directed self-checking bench for the circle engine
module tb_tt_um_jonathancortez_circle_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        pix_valid, frame_start, cfg_valid, cfg_ready;
  logic [2:0]  cfg_idx, cfg_addr;
  logic [23:0] cfg_data;
  logic [7:0]  red, green, blue;
  logic        out_valid, hit_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_jonathancortez_circle_engine dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .pix_valid(pix_valid), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .red(red), .green(green), .blue(blue),
    .out_valid(out_valid), .hit_any(hit_any)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic [2:0] addr, input logic [23:0] data);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_idx = idx; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // frame_start with optional same-cycle write; checks cfg_ready low for COMMIT + 4 ANIM cycles.
  task automatic frame(input logic w, input logic [2:0] idx, input logic [2:0] addr, input logic [23:0] data);
    @(negedge clk);
    frame_start = 1'b1;
    cfg_valid = w; cfg_idx = idx; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    frame_start = 1'b0; cfg_valid = 1'b0;
    chk("ready_commit", 32'(cfg_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ready_anim", 32'(cfg_ready), 32'd0);
    end
    @(negedge clk);
    chk("ready_idle", 32'(cfg_ready), 32'd1);
  endtask

  task automatic px(input string tag, input logic [9:0] h, input logic [9:0] v,
                    input logic [23:0] col, input logic hit);
    @(negedge clk);
    hcount = h; vcount = v; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_rgb"}, 32'({red, green, blue}), 32'(col));
    chk({tag, "_hit"}, 32'(hit_any), 32'(hit));
  endtask

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = '0; pix_valid = 1'b0; frame_start = 1'b0;
    cfg_valid = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_hit", 32'(hit_any), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;

    wr(0, 0, 320); wr(0, 1, 240); wr(0, 2, 50); wr(0, 4, 24'hFFFFFF); wr(0, 7, 1);
    px("pre_commit", 320, 240, 24'h0, 1'b0);
    frame(0, 0, 0, 0);
    px("fill_ctr", 320, 240, 24'hFFFFFF, 1'b1);
    px("fill_out", 371, 240, 24'h0, 1'b0);
    px("fill_edge", 370, 240, 24'hFFFFFF, 1'b1);

    wr(0, 3, 10);
    frame(0, 0, 0, 0);
    px("ring_ctr", 320, 240, 24'h0, 1'b0);
    px("ring_in", 365, 240, 24'hFFFFFF, 1'b1);
    px("ring_outer", 370, 240, 24'hFFFFFF, 1'b1);
    px("ring_hole", 339, 240, 24'h0, 1'b0);
    px("ring_inner_edge", 360, 240, 24'h0, 1'b0);

    wr(0, 0, 200);
    px("shadow_old", 365, 240, 24'hFFFFFF, 1'b1);
    frame(0, 0, 0, 0);
    px("shadow_new", 245, 240, 24'hFFFFFF, 1'b1);
    px("shadow_gone", 365, 240, 24'h0, 1'b0);

    wr(0, 0, 999); wr(0, 0, 100); wr(0, 1, 100); wr(0, 2, 20); wr(0, 3, 0); wr(0, 4, 24'hFF0000);
    wr(1, 0, 110); wr(1, 1, 100); wr(1, 2, 20); wr(1, 4, 24'h0000FF); wr(1, 7, 1);
    frame(0, 0, 0, 0);
    px("prio_both", 115, 100, 24'hFF0000, 1'b1);
    px("prio_c1", 125, 100, 24'h0000FF, 1'b1);
    wr(0, 7, 0);
    frame(0, 0, 0, 0);
    px("prio_c0_off", 115, 100, 24'h0000FF, 1'b1);

    wr(2, 0, 50); wr(2, 1, 50); wr(2, 2, 0); wr(2, 4, 24'h00FF00); wr(2, 7, 1);
    wr(5, 7, 1);
    frame(0, 0, 0, 0);
    px("r0_ctr", 50, 50, 24'h00FF00, 1'b1);
    px("r0_off", 51, 50, 24'h0, 1'b0);
    @(negedge clk);
    hcount = 50; vcount = 50; pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("nopix_valid", 32'(out_valid), 32'd0);
    chk("nopix_rgb", 32'({red, green, blue}), 32'd0);
    chk("nopix_hit", 32'(hit_any), 32'd0);

    frame(1, 2, 7, 0);
    px("same_cycle_wr", 50, 50, 24'h0, 1'b0);

    wr(3, 0, 630); wr(3, 1, 200); wr(3, 2, 10); wr(3, 4, 24'h123456); wr(3, 5, 5); wr(3, 7, 3);
    frame(0, 0, 0, 0);
    px("bounce1_hit", 620, 200, 24'h123456, 1'b1);
    px("bounce1_miss", 615, 200, 24'h0, 1'b0);
    frame(0, 0, 0, 0);
    px("bounce2_hit", 615, 200, 24'h123456, 1'b1);
    px("bounce2_miss", 636, 200, 24'h0, 1'b0);

    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("anim_rst_ready", 32'(cfg_ready), 32'd1);
    chk("anim_rst_rgb", 32'({red, green, blue}), 32'd0);
    chk("anim_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    px("post_rst_c3", 615, 200, 24'h0, 1'b0);
    px("post_rst_c1", 125, 100, 24'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
